// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch stage and the memory
//   stage. One transaction is in flight at a time and moves through
//   IDLE -> ISSUE -> WAIT -> RESP. Each transaction ends with a one-cycle
//   acknowledge to its owner. Data requests win arbitration by default. A
//   saturating streak counter stops a run of data grants from starving a
//   pending fetch indefinitely.
//
// Ports
//   clk, reset              single clock; synchronous active-high reset
//   i_req/i_addr            fetch request and address (held until i_ack)
//   i_ack/i_rdata           fetch acknowledge pulse and registered instruction
//   i_stall                 i_req & ~i_ack
//   d_req/d_we/d_addr/      load/store request (held until d_ack)
//     d_wdata
//   d_ack/d_rdata           data acknowledge pulse and registered load data
//   d_stall                 d_req & ~d_ack
//   mem_req/mem_we/         memory request towards the unified memory
//     mem_addr/mem_wdata
//   mem_ready               memory accepts when mem_req & mem_ready
//   mem_rvalid/mem_rdata    completion pulse and read data
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } stateT;

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

  stateT       state;
  stateT       stateNext;
  logic        owner;      // 0 = fetch, 1 = data
  logic        ownerWe;    // granted transaction is a store
  logic [3:0]  dStreak;
  logic        grant;
  logic        grantData;

  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    grantData = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant     = 1'b1;
          grantData = d_req && !(i_req && (dStreak == MaxStreak));
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        mem_we  = ownerWe;
        if (mem_ready) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        // Requests are not arbitrated here: the acked requester may be
        // dropping its request in this very cycle.
        i_ack     = !owner;
        d_ack     = owner;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    i_stall = i_req && !i_ack;
    d_stall = d_req && !d_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      ownerWe   <= 1'b0;
      dStreak   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state <= stateNext;
      // Address/data are latched at grant; requesters hold them stable until
      // ack, so this matches driving them straight from the owner's inputs.
      if (grant) begin
        owner     <= grantData;
        ownerWe   <= grantData && d_we;
        mem_addr  <= grantData ? d_addr : i_addr;
        mem_wdata <= grantData ? d_wdata : '0;
        if (grantData && i_req) begin
          if (dStreak < MaxStreak) begin
            dStreak <= dStreak + 4'd1;
          end
        end else begin
          dStreak <= '0;
        end
      end
      if ((state == WAIT) && mem_rvalid) begin
        if (!owner) begin
          i_rdata <= mem_rdata;
        end else if (!ownerWe) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. Two requester processes and a memory
// responder drive the DUT; a transaction-level reference model predicts the
// winner of each arbitration, the bus fields, the ack cycle and the returned
// data from its own copy of memory.
module tb_mem_port_arbiter;

  localparam int          MaxD      = 4;
  localparam int          NumCycles = 5500;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_STREAK(MaxD)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .i_stall    (i_stall),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_stall    (d_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      if (errorCount <= 40) begin
        $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
    end
  endtask

  // Reference memory (updated from predicted transactions) and responder
  // memory (updated from what the DUT actually puts on the bus).
  logic [31:0] refMem  [logic [31:0]];
  logic [31:0] respMem [logic [31:0]];

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return a * 32'h0001_0003 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] respRead(input logic [31:0] a);
    return respMem.exists(a) ? respMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] newAddr();
    return 32'h100 + 32'($urandom_range(0, 63) * 4);
  endfunction

  // Reference model: the single transaction in flight, its progress flags,
  // the starvation count and the expected contents of the rdata registers.
  bit          inFlight, accepted, completed, tOwner, tWe;
  logic [31:0] tAddr, tWdata, tRead;
  int          streak;
  logic [31:0] expIr, expDr;
  bit          afterReset;

  // Memory responder state.
  bit          outstanding, lateRv, rvOut;
  int          cd;
  logic [31:0] rdData;

  // Requesters.
  bit          iPend, dPend, prevIwait, prevDwait;

  // Starvation run tracking while both requesters are saturated.
  int          dSinceI;
  bit          seenI;

  initial begin
    bit          inReset, phaseB, waiting, ackNow, issuing, expIack, expDack;
    int unsigned pI, pD, pReady;

    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    inFlight = 0; accepted = 0; completed = 0; tOwner = 0; tWe = 0;
    tAddr = '0; tWdata = '0; tRead = '0; streak = 0; expIr = '0; expDr = '0;
    afterReset = 0; outstanding = 0; lateRv = 0; rvOut = 0; cd = 0; rdData = '0;
    iPend = 0; dPend = 0; prevIwait = 0; prevDwait = 0; dSinceI = 0; seenI = 0;

    for (int n = 0; n < NumCycles; n++) begin
      @(posedge clk);
      #1;
      phaseB = (n >= 2500) && (n < 3500);
      if (n < 2500) begin
        pI = 50; pD = 50; pReady = 70;
      end else if (phaseB) begin
        pI = 100; pD = 100; pReady = 100;
      end else begin
        pI = 85; pD = 35; pReady = 40;
      end

      waiting = inFlight && accepted && !completed;
      if (n < 3) inReset = 1'b1;
      else if (phaseB) inReset = 1'b0;
      else inReset = (waiting && ($urandom_range(0, 19) == 0)) || ($urandom_range(0, 299) == 0);
      reset = inReset;

      if (inReset) begin
        iPend = 0;
        dPend = 0;
      end else begin
        if (!iPend && ($urandom_range(0, 99) < pI)) begin
          iPend  = 1;
          i_addr = newAddr();
        end
        if (!dPend && ($urandom_range(0, 99) < pD)) begin
          dPend   = 1;
          d_addr  = newAddr();
          d_we    = 1'($urandom_range(0, 1));
          d_wdata = $urandom;
        end
      end
      i_req = iPend;
      d_req = dPend;

      if (!inReset && prevIwait) assert (i_req) else $error("fetch request dropped before its acknowledge");
      if (!inReset && prevDwait) assert (d_req) else $error("data request dropped before its acknowledge");

      mem_ready = ($urandom_range(0, 99) < pReady);
      rvOut = 0;
      if (lateRv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        lateRv     = 0;
      end else if (outstanding && (cd == 0)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdData;
        rvOut      = 1;
      end else if (!outstanding && !phaseB && ($urandom_range(0, 7) == 0)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end

      #1;
      ackNow  = inFlight && completed;
      issuing = inFlight && !accepted;
      expIack = ackNow && !tOwner;
      expDack = ackNow && tOwner;

      if (!inReset) begin
        checkVal("i_ack",   32'(i_ack),   32'(expIack));
        checkVal("d_ack",   32'(d_ack),   32'(expDack));
        checkVal("mem_req", 32'(mem_req), 32'(issuing));
        checkVal("i_stall", 32'(i_stall), 32'(i_req && !expIack));
        checkVal("d_stall", 32'(d_stall), 32'(d_req && !expDack));
        checkVal("i_rdata", i_rdata, expIr);
        checkVal("d_rdata", d_rdata, expDr);
        if (issuing) begin
          checkVal("mem_addr", mem_addr, tAddr);
          checkVal("mem_we",   32'(mem_we), 32'(tWe));
          if (tWe) checkVal("mem_wdata", mem_wdata, tWdata);
        end
        if (afterReset) begin
          checkVal("rst_mem_addr",  mem_addr,  32'h0);
          checkVal("rst_mem_wdata", mem_wdata, 32'h0);
          checkVal("rst_mem_we",    32'(mem_we), 32'h0);
        end
        if (phaseB) begin
          if (d_ack) dSinceI++;
          if (i_ack) begin
            if (seenI) checkVal("d_streak_run", 32'(dSinceI), 32'(MaxD));
            seenI   = 1;
            dSinceI = 0;
          end
        end
      end

      // Advance the reference model with this cycle's inputs.
      if (inReset) begin
        inFlight   = 0;
        streak     = 0;
        expIr      = '0;
        expDr      = '0;
        afterReset = 1;
      end else begin
        afterReset = 0;
        if (issuing) begin
          if (mem_ready) begin
            accepted = 1;
            if (tWe) refMem[tAddr] = tWdata;
            else tRead = refRead(tAddr);
          end
        end else if (inFlight && !completed) begin
          if (mem_rvalid) begin
            completed = 1;
            if (!tOwner) expIr = tRead;
            else if (!tWe) expDr = tRead;
          end
        end else if (ackNow) begin
          inFlight = 0;
        end else if (i_req || d_req) begin
          // Data is the older instruction and wins unless the fetch has
          // already waited through MaxD consecutive data grants.
          tOwner = d_req && !(i_req && (streak == MaxD));
          if (tOwner && i_req) streak = (streak < MaxD) ? streak + 1 : MaxD;
          else streak = 0;
          inFlight  = 1;
          accepted  = 0;
          completed = 0;
          tAddr     = tOwner ? d_addr : i_addr;
          tWe       = tOwner && d_we;
          tWdata    = d_wdata;
        end
      end

      // Memory responder bookkeeping.
      if (rvOut) outstanding = 0;
      else if (outstanding) cd--;
      if (inReset) begin
        lateRv      = outstanding;
        outstanding = 0;
      end else if (mem_req && mem_ready) begin
        outstanding = 1;
        cd = phaseB ? 0 : int'($urandom_range(0, 2));
        if (mem_we) begin
          respMem[mem_addr] = mem_wdata;
          rdData = $urandom;
        end else begin
          rdData = respRead(mem_addr);
        end
      end

      // Requesters retire on their ack.
      if (inReset) begin
        prevIwait = 0;
        prevDwait = 0;
      end else begin
        prevIwait = i_req && !i_ack;
        prevDwait = d_req && !d_ack;
        if (i_ack) iPend = 0;
        if (d_ack) dPend = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
